square_accumulator: RTL and testbench
=====================================

// Module: square_accumulator
// PURPOSE
//  Downstream consumer of the 3-bit square lookup stage. Accepts a stream of squared values
//  over a valid/ready handshake and accumulates a frame of up to N_SAMPLES beats.
//  Presents the frame's sum, maximum and beat count on a held output handshake.
//  Frames end on the N_SAMPLES-th beat or on an early in_last.
// PARAMETERS
//  N_SAMPLES  8   beats per full frame, >=2
//  IN_W       8   width of in_sq; matches the square stage output
//  SUM_W      11  accumulator width; elaboration error if SUM_W < IN_W+$clog2(N_SAMPLES)
//  CNT_W      4   beat counter width, must hold N_SAMPLES
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_sq/in_last valid
//  in_ready   out  1      block can accept a beat
//  in_sq      in   IN_W   squared value
//  in_last    in   1      this beat closes the frame early
//  out_valid  out  1      frame result available
//  out_ready  in   1      downstream accepts result
//  out_sum    out  SUM_W  sum of frame beats
//  out_max    out  IN_W   largest in_sq in frame
//  out_count  out  CNT_W  beats in frame (1..N_SAMPLES)
//  busy       out  1      at least one beat accumulated or result pending
// BEHAVIOUR
//  Reset: state=ACCUM; acc, max, cnt = 0; out_valid=0; out_sum/out_max/out_count=0; busy=0.
//   in_ready=1 directly after reset release.
//  States: ACCUM, DONE. Registers are cleared only on reset or on the output handshake.
//  ACCUM: in_ready=1. Beat accepted when in_valid&&in_ready.
//   - On a beat: acc<=acc+in_sq, max<=max(max,in_sq), cnt<=cnt+1.
//  Close condition: beat with cnt==N_SAMPLES-1 or in_last=1.
//   - On close: out_sum/out_max/out_count <= values including this beat; out_valid<=1; ->DONE.
//   - Latency: out_valid rises 1 cycle after the closing beat.
//  DONE: in_ready=0, so no beats are accepted. Outputs are held stable while out_ready=0.
//   - On out_valid&&out_ready: out_valid<=0; acc, max, cnt <= 0; ->ACCUM.
//   - A new beat can be accepted in the cycle after the handshake.
//  in_ready is combinational from state only (no in_valid->in_ready or out_ready->in_ready path).
//  in_last on the N_SAMPLES-th beat: single close, out_count=N_SAMPLES.
//  in_last on the first beat: frame of 1; out_sum=in_sq, out_max=in_sq, out_count=1.
//  Arithmetic: in_sq is zero-extended to SUM_W. Sizing rule makes overflow impossible; no saturation logic.
//  busy = (cnt!=0) || (state==DONE).
//  in_valid while in DONE: ignored. Upstream holds the beat until in_ready.
//  Reset asserted mid-frame or in DONE: all state cleared immediately. Partial frame is discarded.
//  No X propagation: outputs are driven from registers only.
// STRUCTURE
//  Shared package sq_pkg holds:
//   - state enum {ACCUM, DONE}
//   - IN_W/SUM_W default constants
//   - a clog2-based minimum-width helper used by the elaboration check
//  Single flat module. Sub-module max_tracker (compare-and-hold register of max) is optional.
//  One always_ff block for state/datapath, one always_comb block for next-state and ready.
// TESTING
//  1 Full frame: beats 0,1,4,9,16,25,36,49 with valid=1 and out_ready=1.
//    -> out_valid 1 cycle after the 8th beat; out_sum=140, out_max=49, out_count=8.
//  2 Early last: beats 4,9,16 with in_last on 16.
//    -> out_sum=29, out_max=16, out_count=3; next frame starts from acc=0.
//  3 Backpressure: out_ready=0 for 5 cycles after close.
//    -> outputs stable, in_ready=0, in_valid beats not consumed.
//    -> out_ready=1 leads to handshake; in_ready=1 next cycle.
//  4 Width corner: 8 beats of 255.
//    -> out_sum=2040, out_max=255, no wrap.
//    -> 1-beat frame of 49 with in_last: out_sum=49, out_count=1.
//  5 Reset mid-frame: 3 beats (1,4,9), then assert rst_n=0 asynchronously.
//    -> outputs 0 and busy=0 immediately.
//    -> after release, frame of 49,49 with in_last gives out_sum=98.
//  6 Gapped input: in_valid toggles 1/0 across a full 8-beat frame of 36.
//    -> out_sum=288, out_count=8; idle cycles do not change acc.

Source files
------------

// File: rtl/square_accumulator_pkg.sv
// Shared constants, state encoding and width helper for the square accumulator.
package sq_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_SUM_W = 11;

  // State encoding, kept as plain constants for legacy tool flows.
  typedef logic [0:0] state_t;
  localparam state_t ACCUM = 1'b0;
  localparam state_t DONE  = 1'b1;

  // Narrowest accumulator that cannot overflow for n beats of in_w-bit values.
  function automatic int unsigned min_sum_w(input int unsigned in_w, input int unsigned n);
    return in_w + $clog2(n);
  endfunction

endpackage

// File: rtl/square_accumulator_if.sv
// Beat input and frame-result output handshakes of the square accumulator.
interface square_accumulator_if
  import sq_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned SUM_W = DEF_SUM_W,
  parameter int unsigned CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_sq;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [IN_W-1:0]  out_max;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport master (
    output in_valid, in_sq, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_count, busy
  );

  modport slave (
    input  in_valid, in_sq, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_count, busy
  );

endinterface

// File: rtl/square_accumulator.sv
// Accumulates sum, max and count of squared beats per frame and holds the result
// on an output handshake until it is consumed.
module square_accumulator
  import sq_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned SUM_W     = DEF_SUM_W,
  parameter int unsigned CNT_W     = 4
) (
  input logic                clk,
  input logic                rst_n,
  square_accumulator_if.slave bus
);

  if (N_SAMPLES < 2) begin : g_bad_n
    $error("N_SAMPLES must be at least 2");
  end
  if (SUM_W < min_sum_w(IN_W, N_SAMPLES)) begin : g_bad_sum_w
    $error("SUM_W too narrow for IN_W and N_SAMPLES");
  end
  if (N_SAMPLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
    $error("CNT_W cannot hold N_SAMPLES");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [SUM_W-1:0] out_sum_q, out_sum_d;
  logic [IN_W-1:0]  out_max_q, out_max_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             in_ready;
  logic             beat;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    max_d       = max_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_count_d = out_count_q;

    // Ready depends on state alone so no combinational path runs through this block.
    in_ready = (state_q == ACCUM);
    beat     = bus.in_valid && in_ready;

    if (beat) begin
      acc_d = acc_q + SUM_W'(bus.in_sq);
      max_d = (bus.in_sq > max_q) ? bus.in_sq : max_q;
      cnt_d = cnt_q + CNT_W'(1);
      if ((cnt_q == LastCnt) || bus.in_last) begin
        out_sum_d   = acc_d;
        out_max_d   = max_d;
        out_count_d = cnt_d;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
    end

    if ((state_q == DONE) && out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      acc_d       = '0;
      max_d       = '0;
      cnt_d       = '0;
      state_d     = ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      max_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      max_q       <= max_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = (cnt_q != '0) || (state_q == DONE);

endmodule

// File: tb/tb_square_accumulator.sv
// Randomised and directed checks of square_accumulator against a frame-level model.
module tb_square_accumulator;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  square_accumulator_if #(.IN_W(8), .SUM_W(11), .CNT_W(4)) bus ();

  square_accumulator #(
    .N_SAMPLES(N),
    .IN_W     (8),
    .SUM_W    (11),
    .CNT_W    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame model: list of accepted beats in the open frame, plus the last closed result.
  int frame_q[$];
  int e_sum, e_max, e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_sum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  function automatic int q_max(input int q[$]);
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send(input int v, input bit last);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_sq    = 8'(v);
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_wait", 32'(w < 50), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    frame_q.push_back(v);
    if (frame_q.size() == N || last) begin
      e_sum = q_sum(frame_q);
      e_max = q_max(frame_q);
      e_cnt = frame_q.size();
      frame_q.delete();
      chk("close_valid", 32'(bus.out_valid), 32'd1);
      chk("close_sum",   32'(bus.out_sum),   32'(e_sum));
      chk("close_max",   32'(bus.out_max),   32'(e_max));
      chk("close_count", 32'(bus.out_count), 32'(e_cnt));
      chk("close_ready", 32'(bus.in_ready),  32'd0);
    end else begin
      chk("open_valid", 32'(bus.out_valid), 32'd0);
      chk("open_busy",  32'(bus.busy),      32'd1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_busy",  32'(bus.busy),      32'(frame_q.size() != 0));
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
    end
  endtask

  // Holds the result for `hold` cycles (optionally with a beat waiting), then takes it.
  task automatic collect(input int hold, input bit pend, input int pend_v);
    bus.out_ready = 1'b0;
    bus.in_valid  = pend;
    bus.in_sq     = 8'(pend_v);
    bus.in_last   = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_sum",   32'(bus.out_sum),   32'(e_sum));
      chk("hold_max",   32'(bus.out_max),   32'(e_max));
      chk("hold_count", 32'(bus.out_count), 32'(e_cnt));
      chk("hold_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_valid", 32'(bus.out_valid), 32'd0);
    chk("hs_ready", 32'(bus.in_ready),  32'd1);
    chk("hs_busy",  32'(bus.busy),      32'd0);
  endtask

  initial begin
    int len;
    bit lst;
    bus.in_valid  = 1'b0;
    bus.in_sq     = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_max",   32'(bus.out_max),   32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_ready", 32'(bus.in_ready),  32'd1);

    // Full frame of squares 0..49.
    for (int i = 0; i < N; i++) send(i * i, 1'b0);
    chk("full_sum_const", 32'(bus.out_sum), 32'd140);
    collect(0, 1'b0, 0);

    // Early last, with 5 cycles of backpressure and a beat waiting upstream.
    send(4, 1'b0);
    send(9, 1'b0);
    send(16, 1'b1);
    chk("early_sum_const", 32'(bus.out_sum), 32'd29);
    collect(5, 1'b1, 200);
    send(200, 1'b1);
    collect(1, 1'b0, 0);

    // Width corner, then a one-beat frame.
    for (int i = 0; i < N; i++) send(255, 1'b0);
    chk("wide_sum_const", 32'(bus.out_sum), 32'd2040);
    collect(2, 1'b0, 0);
    send(49, 1'b1);
    chk("one_count_const", 32'(bus.out_count), 32'd1);
    collect(0, 1'b0, 0);

    // in_last on the final beat of a full frame closes only once.
    for (int i = 0; i < N; i++) send(i + 1, i == N - 1);
    collect(0, 1'b0, 0);
    idle(2);

    // Asynchronous reset mid-frame discards the partial frame.
    send(1, 1'b0);
    send(4, 1'b0);
    send(9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy),      32'd0);
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sum",   32'(bus.out_sum),   32'd0);
    frame_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(49, 1'b0);
    send(49, 1'b1);
    chk("arst_sum_const", 32'(bus.out_sum), 32'd98);
    collect(0, 1'b0, 0);

    // Gapped frame of 36s.
    for (int i = 0; i < N; i++) begin
      send(36, 1'b0);
      if (i < N - 1) idle(1);
    end
    chk("gap_sum_const", 32'(bus.out_sum), 32'd288);
    collect(0, 1'b0, 0);

    // Random frames.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        lst = (i == len - 1) && ((len < N) || ($urandom % 2 == 1));
        send($urandom_range(0, 255), lst);
        if (i < len - 1) idle($urandom_range(0, 2));
      end
      collect($urandom_range(0, 3), 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

endmodule
